msg_serializer: RTL

MSG_SERIALIZER -- requirements
Module: msg_serializer

---
 rtl/msg_pkg.sv | 35 +++
 rtl/msg_serializer.sv | 97 +++++++++
 2 files changed

// File: rtl/msg_pkg.sv
// Shared definitions for the message serializer: field geometry, framing constants,
// FSM states and the byte-index map of a transmitted frame.
package msg_pkg;

  localparam int          FIELD_W     = 8;
  localparam int          FIELD_N     = 5;
  localparam logic [7:0]  SOF_DEFAULT = 8'h7E;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    LOAD = 2'd2,
    SEND = 2'd3
  } state_t;

  localparam logic [2:0] IDX_SOF  = 3'd0;
  localparam logic [2:0] IDX_AL   = 3'd1;
  localparam logic [2:0] IDX_DID  = 3'd2;
  localparam logic [2:0] IDX_SID  = 3'd3;
  localparam logic [2:0] IDX_ADDR = 3'd4;
  localparam logic [2:0] IDX_DATA = 3'd5;
  localparam logic [2:0] IDX_CSUM = 3'd6;

  // Frame checksum covers the five message fields only; the SOF byte is excluded.
  function automatic logic [FIELD_W-1:0] msg_checksum(
    input logic [FIELD_W-1:0] al,
    input logic [FIELD_W-1:0] did,
    input logic [FIELD_W-1:0] sid,
    input logic [FIELD_W-1:0] addr,
    input logic [FIELD_W-1:0] data
  );
    return al ^ did ^ sid ^ addr ^ data;
  endfunction

endpackage

// File: rtl/msg_serializer.sv
// Pops one message from an upstream FIFO and sends it as a 7-byte frame
// (SOF, five fields, XOR checksum) over a valid/ready byte link.
module msg_serializer
  import msg_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE = SOF_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  Al_Dl_101,
  input  logic [7:0]  D_ID,
  input  logic [7:0]  S_ID,
  input  logic [7:0]  M_Addr,
  input  logic [7:0]  M_Data,
  input  logic        my_empty_flag,
  output logic        my_read_flag,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic [15:0] frames_sent
);

  state_t      state, state_nxt;
  logic [2:0]  idx;
  logic [7:0]  al_q, did_q, sid_q, addr_q, data_q;
  logic        xfer;

  assign xfer = (state == SEND) && tx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= IDX_SOF;
      al_q        <= '0;
      did_q       <= '0;
      sid_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      frames_sent <= '0;
    end else begin
      state <= state_nxt;
      if (my_read_flag) begin
        al_q   <= Al_Dl_101;
        did_q  <= D_ID;
        sid_q  <= S_ID;
        addr_q <= M_Addr;
        data_q <= M_Data;
        idx    <= IDX_SOF;
      end else if (xfer) begin
        idx <= idx + 3'd1;
        if (idx == IDX_CSUM) begin
          frames_sent <= frames_sent + 16'd1;
        end
      end
    end
  end

  // Link outputs decode from state and captured registers only; tx_ready steers
  // nothing but the next-state and index update, so a stalled byte stays put.
  always_comb begin
    state_nxt    = state;
    my_read_flag = 1'b0;
    tx_valid     = 1'b0;
    tx_last      = 1'b0;
    tx_data      = 8'h00;
    case (state)
      IDLE: if (!my_empty_flag) state_nxt = WAIT;
      WAIT: state_nxt = LOAD;
      LOAD: begin
        // A FIFO that drained during WAIT is never popped; fall back to IDLE.
        if (my_empty_flag) begin
          state_nxt = IDLE;
        end else begin
          my_read_flag = 1'b1;
          state_nxt    = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_last  = (idx == IDX_CSUM);
        case (idx)
          IDX_SOF:  tx_data = SOF_BYTE;
          IDX_AL:   tx_data = al_q;
          IDX_DID:  tx_data = did_q;
          IDX_SID:  tx_data = sid_q;
          IDX_ADDR: tx_data = addr_q;
          IDX_DATA: tx_data = data_q;
          default:  tx_data = msg_checksum(al_q, did_q, sid_q, addr_q, data_q);
        endcase
        if (tx_ready && idx == IDX_CSUM) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
